vg_fetch_pc: RTL and testbench
==============================

Name: vg_fetch_pc

Overview:
- Vector-program fetch stage for the AVG.
- Holds the 13-bit vector program counter and the 4-entry subroutine stack, and captures the four instruction bytes from vector memory.
- Presents `op[2:0]` to the vector-generator state machine and consumes that machine's active-low latch/strobe pulses.
- Downstream consumers (vector timer, beam position, scale/colour registers) take the latched data word `dr`.

Parameters:
- AW, 13, program-counter / vector-memory word-address width.
- SPW, 2, stack-pointer width; stack depth is 2^SPW entries.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- vggo  in  1  one-cycle start pulse from the CPU; restarts the program at address 0.
- latch_n  in  4  active-low one-cycle byte-latch enables; bit n writes data register n.
- strobe_n  in  4  active-low one-cycle strobes from the state machine.
- vmem_data  in  8  byte read from vector memory at the current address.
- vmem_addr  out  AW  current word address; equals `pc`.
- op  out  3  equals `dr1[7:5]`; feeds the state-machine opcode input.
- dr  out  32  `{dr3,dr2,dr1,dr0}` to downstream stages.
- sp  out  SPW  stack pointer, for debug/visibility.

Behaviour:
- Reset (async, active-high) clears everything to 0: `pc`, `sp`, `dr0`–`dr3`, and all stack entries. Therefore `vmem_addr`=0, `op`=0, `dr`=0, `sp`=0. Release is synchronous to the next clk edge.
- Opcode encodings:
  - 000 VCTR
  - 001 HALT
  - 010 SVEC
  - 011 STAT/SCAL
  - 100 CENTER
  - 101 JSR
  - 110 RTS
  - 111 JMP
- Priority each cycle: reset > vggo > strobes > latches.
- vggo:
  - Sets `pc`←0 and `sp`←0 on that edge; stack contents are preserved.
  - All latch and strobe inputs in the same cycle are ignored.
- Latches:
  - When `latch_n[k]`=0, `dr_k`←`vmem_data` on that edge.
  - Byte map: `dr1` = word0 high (opcode), `dr0` = word0 low, `dr3` = word1 high, `dr2` = word1 low.
- PC increment (+1, modulo 2^AW, wraps 1FFF→0000):
  - On a `latch_n[0]` pulse.
  - On a `latch_n[2]` pulse.
  - On a `latch_n[3]` pulse while `op`=SVEC. SVEC is a single word and skips latch0.
- At most one increment per cycle, even if several latch bits are asserted. Multiple asserted latch bits is illegal stimulus, but each asserted `dr_k` is still written.
- Increment uses the `op` value before the edge. Latch1 writing `dr1` in the same cycle does not affect that cycle's increment decision.
- Strobes (`op` sampled before the edge):
  - strobe1 with JSR: `stack[sp]`←`pc` and `sp`←`sp`+1. `pc` already points past the JSR word.
  - strobe1 with RTS: `sp`←`sp`−1.
  - strobe2 with JMP or JSR: `pc`←`{dr1[4:0],dr0}` (AW bits).
  - strobe2 with RTS: `pc`←`stack[sp]`. This reads the already-decremented `sp` from the previous strobe1.
  - strobe0, strobe3, and strobe1/strobe2 with any other opcode: no effect on `pc`/`sp`.
- Strobe/latch collision: a strobe that loads `pc` overrides any same-cycle increment.
- Stack wrap:
  - `sp` is modulo 2^SPW and wraps silently.
  - A fifth nested JSR overwrites entry 0.
  - RTS with `sp`=0 wraps to 3 and returns `stack[3]`.
  - No error flag.
- Latency: `vmem_addr`, `dr`, `op` and `sp` are registered outputs and update on the clk edge of the causing pulse. `vmem_addr` is valid for the next latch one cycle later.
- Reset asserted mid-instruction immediately zeroes all state. No partial push or partial pc load survives.

Test Plan:
1. Reset: assert reset with random inputs → `vmem_addr`=0, `sp`=0, `dr`=0, `op`=0. Release, idle 5 cycles → unchanged.
2. VCTR fetch from `pc`=0x010: latch1 (data 0x1F), latch0 (0x40), latch3 (0x05), latch2 (0x80) → `dr`=0x05801F40, `op`=000, `pc`=0x012.
3. SVEC at `pc`=0x020: latch1 (0x5A), latch3 (0x33) → `op`=010, `pc`=0x021, `dr1`=0x5A, `dr3`=0x33.
4. JMP: latch1=0xE1, latch0=0x23 at `pc`=0x100, then strobe2 → `pc`=0x123, `sp` unchanged. Same cycle as a latch0 pulse → `pc`=0x123, no increment.
5. JSR/RTS: JSR target 0x0200 fetched at 0x050 (`pc`=0x051), strobe1, strobe2 → `stack[0]`=0x051, `sp`=1, `pc`=0x200. Later RTS, strobe1, strobe2 → `sp`=0, `pc`=0x051.
6. Stack wrap and vggo:
   - Five nested JSRs → `sp`=1, `stack[0]` holds the 5th return address.
   - vggo asserted together with a strobe2 → `pc`=0, `sp`=0; strobe ignored; stack entries intact.

Source files
------------

// File: rtl/vg_fetch_pc.sv
// ---------------------------------------------------------------------------
// vg_fetch_pc -- vector-program fetch stage for the AVG.
//
// This block holds the vector program counter and a small subroutine return
// stack. It captures the four instruction bytes from vector memory and
// presents the opcode to the vector-generator state machine. That machine
// steers this block with active-low one-cycle latch and strobe pulses.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset      asynchronous active-high clear of every register
//   vggo       one-cycle restart: pc and sp go to 0; latches and strobes in
//              the same cycle are ignored
//   latch_n    active-low byte latch enables, bit k writes dr_k
//   strobe_n   active-low strobes from the state machine
//              (bit 1 = stack op, bit 2 = pc load)
//   vmem_data  byte read from vector memory at vmem_addr
//   vmem_addr  current word address (the program counter)
//   op         opcode, dr1[7:5]
//   dr         {dr3, dr2, dr1, dr0} for the downstream stages
//   sp         stack pointer, for visibility
// ---------------------------------------------------------------------------
module vg_fetch_pc #(
  parameter int AW  = 13,
  parameter int SPW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           vggo,
  input  logic [3:0]     latch_n,
  input  logic [3:0]     strobe_n,
  input  logic [7:0]     vmem_data,
  output logic [AW-1:0]  vmem_addr,
  output logic [2:0]     op,
  output logic [31:0]    dr,
  output logic [SPW-1:0] sp
);

  localparam int DEPTH = 1 << SPW;

  localparam logic [2:0] OP_SVEC = 3'b010;
  localparam logic [2:0] OP_JSR  = 3'b101;
  localparam logic [2:0] OP_RTS  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [7:0]     dr_q [4];
  logic [AW-1:0]  stack_q [DEPTH];
  logic [3:0]     lat_en;
  logic           push;
  logic           unused_strobes;

  // Jump/call target: the low five bits of the opcode byte are the high
  // address bits, and the low byte of the first word is the low address byte.
  function automatic logic [AW-1:0] jump_target(input logic [7:0] hi,
                                                input logic [7:0] lo);
    logic [12:0] t;
    t = {hi[4:0], lo};
    return AW'(t);
  endfunction

  // Strobes 0 and 3 belong to other stages of the generator.
  assign unused_strobes = &{1'b0, strobe_n[0], strobe_n[3]};

  // Decisions below use op as it stood before the edge. A latch1 in the same
  // cycle only changes op from the next cycle onwards.
  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    push   = 1'b0;
    lat_en = 4'b0000;
    if (vggo) begin
      pc_d = '0;
      sp_d = '0;
    end else begin
      lat_en = ~latch_n;
      // One increment at most, however many latches are asserted.
      // SVEC is a single word, so its latch3 also advances the pc.
      if (!latch_n[0] || !latch_n[2] || (!latch_n[3] && op == OP_SVEC)) begin
        pc_d = pc_q + AW'(1);
      end
      if (!strobe_n[1]) begin
        if (op == OP_JSR) begin
          push = 1'b1;
          sp_d = sp_q + SPW'(1);
        end else if (op == OP_RTS) begin
          sp_d = sp_q - SPW'(1);
        end
      end
      // A pc load overrides any same-cycle increment. RTS reads the entry
      // under the pointer, which the preceding strobe1 has already moved.
      if (!strobe_n[2]) begin
        if (op == OP_JMP || op == OP_JSR) begin
          pc_d = jump_target(dr_q[1], dr_q[0]);
        end else if (op == OP_RTS) begin
          pc_d = stack_q[sp_q];
        end
      end
    end
  end

  // Register stage: pc, sp, instruction bytes and return stack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
      sp_q <= '0;
      for (int i = 0; i < 4; i++) begin
        dr_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      pc_q <= pc_d;
      sp_q <= sp_d;
      for (int i = 0; i < 4; i++) begin
        if (lat_en[i]) begin
          dr_q[i] <= vmem_data;
        end
      end
      // The return address is the pc already past the JSR word.
      if (push) begin
        stack_q[sp_q] <= pc_q;
      end
    end
  end

  assign vmem_addr = pc_q;
  assign op        = dr_q[1][7:5];
  assign dr        = {dr_q[3], dr_q[2], dr_q[1], dr_q[0]};
  assign sp        = sp_q;

endmodule

// File: tb/tb_vg_fetch_pc.sv
module tb_vg_fetch_pc;

  logic        clk;
  logic        reset;
  logic        vggo;
  logic [3:0]  latch_n;
  logic [3:0]  strobe_n;
  logic [7:0]  vmem_data;
  logic [12:0] vmem_addr;
  logic [2:0]  op;
  logic [31:0] dr;
  logic [1:0]  sp;

  int errs;
  int checks;

  vg_fetch_pc #(.AW(13), .SPW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .vggo      (vggo),
    .latch_n   (latch_n),
    .strobe_n  (strobe_n),
    .vmem_data (vmem_data),
    .vmem_addr (vmem_addr),
    .op        (op),
    .dr        (dr),
    .sp        (sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: plain integers and byte array.
  int         m_pc;
  int         m_sp;
  int         m_stack [4];
  logic [7:0] m_dr [4];
  int         m_op;
  int         m_npc;
  int         m_nsp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 0;
      m_sp = 0;
      for (int i = 0; i < 4; i++) begin
        m_stack[i] = 0;
        m_dr[i]    = 8'h00;
      end
    end else if (vggo) begin
      m_pc = 0;
      m_sp = 0;
    end else begin
      m_op  = int'(m_dr[1]) / 32;
      m_npc = m_pc;
      m_nsp = m_sp;
      if (latch_n[0] == 1'b0 || latch_n[2] == 1'b0 || (latch_n[3] == 1'b0 && m_op == 2))
        m_npc = (m_pc + 1) % 8192;
      if (strobe_n[1] == 1'b0 && m_op == 5) begin
        m_stack[m_sp] = m_pc;
        m_nsp = (m_sp + 1) % 4;
      end
      if (strobe_n[1] == 1'b0 && m_op == 6)
        m_nsp = (m_sp + 3) % 4;
      if (strobe_n[2] == 1'b0 && (m_op == 5 || m_op == 7))
        m_npc = (int'(m_dr[1]) % 32) * 256 + int'(m_dr[0]);
      if (strobe_n[2] == 1'b0 && m_op == 6)
        m_npc = m_stack[m_sp];
      for (int k = 0; k < 4; k++) begin
        if (latch_n[k] == 1'b0) m_dr[k] = vmem_data;
      end
      m_pc = m_npc;
      m_sp = m_nsp;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_pc", 32'(vmem_addr), 32'(m_pc));
    chk("model_sp", 32'(sp), 32'(m_sp));
    chk("model_dr", dr, {m_dr[3], m_dr[2], m_dr[1], m_dr[0]});
    chk("model_op", 32'(op), 32'(m_dr[1][7:5]));
  end

  task automatic step(input logic g, input logic [3:0] ln, input logic [3:0] sn,
                      input logic [7:0] d);
    vggo      = g;
    latch_n   = ln;
    strobe_n  = sn;
    vmem_data = d;
    @(posedge clk);
    #1;
    vggo     = 1'b0;
    latch_n  = 4'hF;
    strobe_n = 4'hF;
  endtask

  task automatic lat(input int k, input logic [7:0] d);
    logic [3:0] m;
    m = 4'b0001 << k;
    step(1'b0, ~m, 4'hF, d);
  endtask

  task automatic strb(input int k);
    logic [3:0] m;
    m = 4'b0001 << k;
    step(1'b0, 4'hF, ~m, 8'h00);
  endtask

  task automatic jmp(input logic [12:0] t);
    lat(1, {3'b111, t[12:8]});
    lat(0, t[7:0]);
    strb(2);
  endtask

  task automatic jsr(input logic [12:0] t);
    lat(1, {3'b101, t[12:8]});
    lat(0, t[7:0]);
    strb(1);
    strb(2);
  endtask

  task automatic rts();
    lat(1, 8'hC0);
    lat(0, 8'h00);
    strb(1);
    strb(2);
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    reset     = 1'b0;
    vggo      = 1'b0;
    latch_n   = 4'hF;
    strobe_n  = 4'hF;
    vmem_data = 8'h00;
    #1 reset = 1'b1;

    // 1. reset with random inputs
    repeat (4) begin
      vggo      = 1'($urandom);
      latch_n   = 4'($urandom);
      strobe_n  = 4'($urandom);
      vmem_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_pc", 32'(vmem_addr), 32'h0);
    chk("rst_sp", 32'(sp), 32'h0);
    chk("rst_dr", dr, 32'h0);
    chk("rst_op", 32'(op), 32'h0);
    vggo     = 1'b0;
    latch_n  = 4'hF;
    strobe_n = 4'hF;
    reset    = 1'b0;
    repeat (5) step(1'b0, 4'hF, 4'hF, 8'h5A);
    chk("idle_pc", 32'(vmem_addr), 32'h0);
    chk("idle_dr", dr, 32'h0);

    // 2. VCTR fetch from 0x010
    jmp(13'h010);
    chk("jmp010_pc", 32'(vmem_addr), 32'h010);
    lat(1, 8'h1F);
    lat(0, 8'h40);
    lat(3, 8'h05);
    lat(2, 8'h80);
    chk("vctr_dr", dr, 32'h05801F40);
    chk("vctr_op", 32'(op), 32'h0);
    chk("vctr_pc", 32'(vmem_addr), 32'h012);

    // 3. SVEC at 0x020
    jmp(13'h020);
    lat(1, 8'h5A);
    lat(3, 8'h33);
    chk("svec_op", 32'(op), 32'h2);
    chk("svec_pc", 32'(vmem_addr), 32'h021);
    chk("svec_dr1", 32'(dr[15:8]), 32'h5A);
    chk("svec_dr3", 32'(dr[31:24]), 32'h33);

    // 4. JMP, then JMP colliding with a latch0 increment
    jmp(13'h100);
    lat(1, 8'hE1);
    lat(0, 8'h23);
    chk("jmp_pre_pc", 32'(vmem_addr), 32'h101);
    strb(2);
    chk("jmp_pc", 32'(vmem_addr), 32'h123);
    chk("jmp_sp", 32'(sp), 32'h0);
    jmp(13'h100);
    lat(1, 8'hE1);
    lat(0, 8'h23);
    step(1'b0, 4'b1110, 4'b1011, 8'h23);
    chk("jmp_coll_pc", 32'(vmem_addr), 32'h123);

    // pc wraps 1FFF -> 0000
    jmp(13'h1FFF);
    chk("wrap_pre", 32'(vmem_addr), 32'h1FFF);
    lat(0, 8'h12);
    chk("wrap_pc", 32'(vmem_addr), 32'h0000);

    // 5. JSR / RTS
    jmp(13'h050);
    lat(1, 8'hA2);
    lat(0, 8'h00);
    chk("jsr_ret_pc", 32'(vmem_addr), 32'h051);
    strb(1);
    chk("jsr_sp", 32'(sp), 32'h1);
    strb(2);
    chk("jsr_pc", 32'(vmem_addr), 32'h200);
    rts();
    chk("rts_sp", 32'(sp), 32'h0);
    chk("rts_pc", 32'(vmem_addr), 32'h051);

    // 6. five nested JSRs: returns 052,301,401,501,601
    jsr(13'h0300);
    jsr(13'h0400);
    jsr(13'h0500);
    jsr(13'h0600);
    jsr(13'h0700);
    chk("nest_sp", 32'(sp), 32'h1);
    chk("nest_pc", 32'(vmem_addr), 32'h700);
    rts();
    chk("nest_rts_pc", 32'(vmem_addr), 32'h601);
    chk("nest_rts_sp", 32'(sp), 32'h0);

    // vggo with a strobe2 and a latch0: both ignored
    step(1'b1, 4'b1110, 4'b1011, 8'hFF);
    chk("vggo_pc", 32'(vmem_addr), 32'h0);
    chk("vggo_sp", 32'(sp), 32'h0);
    chk("vggo_dr0", 32'(dr[7:0]), 32'h00);
    // RTS from sp=0 wraps to 3 and shows stack[3] survived vggo
    strb(1);
    chk("rts_wrap_sp", 32'(sp), 32'h3);
    strb(2);
    chk("rts_wrap_pc", 32'(vmem_addr), 32'h501);

    // reset mid-instruction clears at once
    jmp(13'h040);
    lat(1, 8'hA3);
    lat(0, 8'h45);
    strb(1);
    reset = 1'b1;
    #1;
    chk("midrst_pc", 32'(vmem_addr), 32'h0);
    chk("midrst_sp", 32'(sp), 32'h0);
    chk("midrst_dr", dr, 32'h0);
    #1 reset = 1'b0;
    step(1'b0, 4'hF, 4'hF, 8'h00);
    chk("postrst_pc", 32'(vmem_addr), 32'h0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
